// File: rtl/vx_mem_req_arb_if.sv
// vx_mem_req_arb_if: N-lane memory request bundle (valid/rw/byteen/addr/data/tag with ready back-pressure)
interface vx_mem_req_arb_if #(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
);
  localparam int DATA_SIZE = DATA_WIDTH / 8;
  logic [N-1:0]            valid;
  logic [N-1:0]            rw;
  logic [N*DATA_SIZE-1:0]  byteen;
  logic [N*ADDR_WIDTH-1:0] addr;
  logic [N*DATA_WIDTH-1:0] data;
  logic [N*TAG_WIDTH-1:0]  tag;
  logic [N-1:0]            ready;
  modport master (output valid, rw, byteen, addr, data, tag, input ready);
  modport slave  (input valid, rw, byteen, addr, data, tag, output ready);
endinterface

// File: rtl/vx_mem_req_arb.sv
// vx_mem_req_arb: round-robin N-to-1 memory request arbiter with registered output; VX_MEM_ARB_PERF_EN adds per-channel stall counters
module vx_mem_req_arb #(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 512,
  parameter int ADDR_WIDTH    = 26,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int DATA_SIZE     = DATA_WIDTH / 8,
  parameter int LOG_NUM_REQS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
`ifdef VX_MEM_ARB_PERF_EN
  , parameter int PERF_CTR_BITS = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_mem_req_arb_if.slave       i_req,
  vx_mem_req_arb_if.master      o_req
`ifdef VX_MEM_ARB_PERF_EN
  , output logic [NUM_REQS*PERF_CTR_BITS-1:0] perf_stall_cycles
`endif
);
  localparam int PTR_W = (NUM_REQS > 1) ? LOG_NUM_REQS : 1;

  logic [PTR_W-1:0]         r_rr_ptr;
  logic [PTR_W-1:0]         w_gnt_idx;
  logic                     w_gnt_valid;
  logic                     w_en;
  logic                     w_fire;
  logic [NUM_REQS-1:0]      w_ready;
  logic [TAG_OUT_WIDTH-1:0] w_tag_out;
  logic                     r_valid;
  logic                     r_rw;
  logic [DATA_SIZE-1:0]     r_byteen;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [TAG_OUT_WIDTH-1:0] r_tag;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    return PTR_W'((j >= NUM_REQS) ? j - NUM_REQS : j);
  endfunction

  // scan from the pointer downward so the channel closest to rr_ptr wins last
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--)
      if (i_req.valid[rr_idx(r_rr_ptr, k)]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = rr_idx(r_rr_ptr, k);
      end
  end

  assign w_en   = !r_valid || o_req.ready;
  assign w_fire = w_gnt_valid && w_en;

  // one-hot accept to the granted channel, held low while in reset
  always_comb begin
    w_ready = '0;
    for (int k = 0; k < NUM_REQS; k++)
      w_ready[k] = reset && w_fire && (w_gnt_idx == PTR_W'(k));
  end

  assign i_req.ready = w_ready;

  if (LOG_NUM_REQS > 0) begin : g_idx
    assign w_tag_out = {i_req.tag[w_gnt_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH], w_gnt_idx};
  end else begin : g_noidx
    assign w_tag_out = i_req.tag[TAG_IN_WIDTH-1:0];
  end

  // output pipeline register; pointer moves just past the channel that fired
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_valid  <= 1'b0;
      r_rw     <= 1'b0;
      r_byteen <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_tag    <= '0;
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_valid  <= 1'b1;
      r_rw     <= i_req.rw[w_gnt_idx];
      r_byteen <= i_req.byteen[w_gnt_idx*DATA_SIZE +: DATA_SIZE];
      r_addr   <= i_req.addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      r_data   <= i_req.data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      r_tag    <= w_tag_out;
      r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_REQS - 1)) ? '0 : w_gnt_idx + 1'b1;
    end else if (o_req.ready) begin
      r_valid  <= 1'b0;
    end

  assign o_req.valid  = r_valid;
  assign o_req.rw     = r_rw;
  assign o_req.byteen = r_byteen;
  assign o_req.addr   = r_addr;
  assign o_req.data   = r_data;
  assign o_req.tag    = r_tag;

`ifdef VX_MEM_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_perf
    logic [PERF_CTR_BITS-1:0] r_cnt;
    // count cycles a request waits unaccepted, sticking at all-ones
    always_ff @(posedge clk or negedge reset)
      if (!reset) r_cnt <= '0;
      else if (i_req.valid[i] && !w_ready[i] && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    assign perf_stall_cycles[i*PERF_CTR_BITS +: PERF_CTR_BITS] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_vx_mem_req_arb.sv
// tb_vx_mem_req_arb: scoreboard bench for the round-robin memory request arbiter (4- and 3-channel instances)
module tb_vx_mem_req_arb;
  localparam int DW = 32, AW = 16, TW = 8, TOW = 10;

  typedef struct packed {logic rw; logic [3:0] be; logic [AW-1:0] addr; logic [DW-1:0] data; logic [TW-1:0] tag;} req_t;
  typedef struct packed {logic rw; logic [3:0] be; logic [AW-1:0] addr; logic [DW-1:0] data; logic [TOW-1:0] tag;} out_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vx_mem_req_arb_if #(.N(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW))  a4 ();
  vx_mem_req_arb_if #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TOW)) b4 ();
  vx_mem_req_arb_if #(.N(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW))  a3 ();
  vx_mem_req_arb_if #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TOW)) b3 ();

`ifdef VX_MEM_ARB_PERF_EN
  logic [15:0] perf4;
  logic [11:0] perf3;
`endif

  vx_mem_req_arb #(.NUM_REQS(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
`ifdef VX_MEM_ARB_PERF_EN
    , .PERF_CTR_BITS(4)
`endif
  ) u4 (.clk(clk), .reset(reset), .i_req(a4), .o_req(b4)
`ifdef VX_MEM_ARB_PERF_EN
    , .perf_stall_cycles(perf4)
`endif
  );

  vx_mem_req_arb #(.NUM_REQS(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
`ifdef VX_MEM_ARB_PERF_EN
    , .PERF_CTR_BITS(4)
`endif
  ) u3 (.clk(clk), .reset(reset), .i_req(a3), .o_req(b3)
`ifdef VX_MEM_ARB_PERF_EN
    , .perf_stall_cycles(perf3)
`endif
  );

  int   n_chk = 0;
  int   n_fail = 0;
  req_t src [4][$];
  out_t exp4 [$];
  out_t exp3 [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic req_t mk(input int c, input int k, input logic [7:0] t);
    req_t r;
    r.rw   = k[0];
    r.be   = 4'(c + k + 1);
    r.addr = 16'(16'h1000 * c + k);
    r.data = 32'hD000_0000 | 32'(c * 256 + k);
    r.tag  = t;
    return r;
  endfunction

  function automatic out_t mk_exp(input req_t r, input int c);
    return {r.rw, r.be, r.addr, r.data, r.tag, 2'(c)};
  endfunction

  function automatic out_t cur4();
    return {b4.rw, b4.byteen, b4.addr, b4.data, b4.tag};
  endfunction

  function automatic out_t cur3();
    return {b3.rw, b3.byteen, b3.addr, b3.data, b3.tag};
  endfunction

  task automatic send(input int c, input req_t r, input bit expect_out);
    src[c].push_back(r);
    if (expect_out) exp4.push_back(mk_exp(r, c));
  endtask

  task automatic present();
    req_t h;
    for (int c = 0; c < 4; c++)
      if (src[c].size() != 0) begin
        h = src[c][0];
        a4.valid[c] = 1'b1;
        a4.rw[c] = h.rw;
        a4.byteen[c*4 +: 4] = h.be;
        a4.addr[c*AW +: AW] = h.addr;
        a4.data[c*DW +: DW] = h.data;
        a4.tag[c*TW +: TW] = h.tag;
      end else a4.valid[c] = 1'b0;
  endtask

  task automatic set3(input int c, input req_t r);
    a3.rw[c] = r.rw;
    a3.byteen[c*4 +: 4] = r.be;
    a3.addr[c*AW +: AW] = r.addr;
    a3.data[c*DW +: DW] = r.data;
    a3.tag[c*TW +: TW] = r.tag;
    exp3.push_back(mk_exp(r, c));
  endtask

  task automatic tick(output logic [3:0] acc4, output logic [2:0] acc3);
    @(negedge clk);
    acc4 = a4.valid & a4.ready;
    acc3 = a3.valid & a3.ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++)
      if (acc4[c]) void'(src[c].pop_front());
    present();
  endtask

  always @(negedge clk)
    if (b4.valid && b4.ready) begin
      if (exp4.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out4_unexpected: got %0h, expected no request", cur4());
      end else check("out4", 64'(cur4()), 64'(exp4.pop_front()));
    end

  always @(negedge clk)
    if (b3.valid && b3.ready) begin
      if (exp3.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out3_unexpected: got %0h, expected no request", cur3());
      end else check("out3", 64'(cur3()), 64'(exp3.pop_front()));
    end

  initial begin
    logic [3:0] acc;
    logic [2:0] acc3;
    req_t r;
    a4.valid = '0; a4.rw = '0; a4.byteen = '0; a4.addr = '0; a4.data = '0; a4.tag = '0;
    a3.valid = '0; a3.rw = '0; a3.byteen = '0; a3.addr = '0; a3.data = '0; a3.tag = '0;
    b4.ready = 1'b1;
    b3.ready = 1'b1;
    a4.valid = 4'hF;
    @(negedge clk);
    check("ready_in_in_reset", 64'(a4.ready), 64'h0);
    check("valid_out_in_reset", 64'(b4.valid), 64'h0);
    a4.valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("ready_in_idle", 64'(a4.ready), 64'h0);
    check("valid_out_idle", 64'(b4.valid), 64'h0);
    check("payload_idle", 64'(cur4()), 64'h0);
    @(posedge clk);
    #1;
    set3(1, mk(1, 0, 8'h11));
    a3.valid = 3'b010;
    tick(acc, acc3);
    check("rr3_first_ch1", 64'(acc3), 64'(3'b010));
    set3(2, mk(2, 0, 8'h22));
    set3(0, mk(0, 0, 8'h20));
    a3.valid = 3'b101;
    tick(acc, acc3);
    check("rr3_ptr2_ch2", 64'(acc3), 64'(3'b100));
    a3.valid = 3'b001;
    tick(acc, acc3);
    check("rr3_wrap_ch0", 64'(acc3), 64'(3'b001));
    a3.valid = 3'b000;
    repeat (2) tick(acc, acc3);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) send(c, mk(c, k, 8'(16 * k + c + 1)), 1'b1);
    present();
    for (int k = 0; k < 8; k++) begin
      tick(acc, acc3);
      check($sformatf("rr4_grant%0d", k), 64'(acc), 64'(4'b0001 << (k % 4)));
    end
    repeat (2) tick(acc, acc3);
    b4.ready = 1'b0;
    r = '{rw: 1'b1, be: 4'hF, addr: 16'h0100, data: 32'hCAFE_0002, tag: 8'h5A};
    send(2, r, 1'b1);
    present();
    tick(acc, acc3);
    check("accept_ch2", 64'(acc), 64'(4'b0100));
    r = '{rw: 1'b0, be: 4'h3, addr: 16'h0200, data: 32'h0BAD_0001, tag: 8'h33};
    send(1, r, 1'b1);
    present();
    for (int s = 0; s < 3; s++) begin
      tick(acc, acc3);
      check($sformatf("stall_ready%0d", s), 64'(acc), 64'h0);
      check($sformatf("stall_valid%0d", s), 64'(b4.valid), 64'h1);
      check($sformatf("stall_tag%0d", s), 64'(b4.tag), 64'h16A);
      check($sformatf("stall_addr%0d", s), 64'(b4.addr), 64'h0100);
    end
    b4.ready = 1'b1;
    tick(acc, acc3);
    check("accept_on_release", 64'(acc), 64'(4'b0010));
    repeat (2) tick(acc, acc3);
    b4.ready = 1'b0;
    send(1, mk(1, 5, 8'h77), 1'b0);
    present();
    tick(acc, acc3);
    check("accept_before_reset", 64'(acc), 64'(4'b0010));
    check("valid_before_reset", 64'(b4.valid), 64'h1);
    reset = 1'b0;
    #1;
    check("valid_async_reset", 64'(b4.valid), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    b4.ready = 1'b1;
    send(0, mk(0, 7, 8'h70), 1'b1);
    send(3, mk(3, 7, 8'h73), 1'b1);
    present();
    tick(acc, acc3);
    check("rr_after_reset_ch0", 64'(acc), 64'(4'b0001));
    tick(acc, acc3);
    check("rr_after_reset_ch3", 64'(acc), 64'(4'b1000));
    repeat (2) tick(acc, acc3);
`ifdef VX_MEM_ARB_PERF_EN
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    b4.ready = 1'b0;
    send(0, mk(0, 8, 8'h80), 1'b1);
    present();
    tick(acc, acc3);
    send(1, mk(1, 8, 8'h81), 1'b1);
    present();
    repeat (20) tick(acc, acc3);
    check("perf_ch0", 64'(perf4[3:0]), 64'h0);
    check("perf_ch1_sat", 64'(perf4[7:4]), 64'hF);
    check("perf_ch2", 64'(perf4[11:8]), 64'h0);
    check("perf_ch3", 64'(perf4[15:12]), 64'h0);
    b4.ready = 1'b1;
    repeat (3) tick(acc, acc3);
`endif
    check("exp4_drained", 64'(exp4.size()), 64'h0);
    check("exp3_drained", 64'(exp3.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
